// File: rtl/ir_rx_letter_buffer.sv
// ir_rx_letter_buffer: receive-side letter buffer for the IR link.
// Filters decoder codes, stores accepted letters in a circular buffer with a
// registered read port, and presents them one at a time on a valid/ready port.
module ir_rx_letter_buffer #(
    parameter int DEPTH = 1000,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear_in,
    input  logic [4:0]       code_in,
    input  logic             new_code_in,
    input  logic [2:0]       error_in,
    input  logic             letter_ready_in,
    output logic             letter_valid_out,
    output logic [4:0]       letter_out,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow_out,
    output logic [7:0]       bad_count_out,
    output logic [7:0]       err_event_count_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;      // accepted, not yet transferred
    logic [CNT_W-1:0] stored_q, stored_d;    // held in the array only
    logic             overflow_q, overflow_d;
    logic [7:0]       bad_q, bad_d;
    logic [7:0]       evt_q, evt_d;
    logic             err_prev_q, err_prev_d;

    logic [4:0]       mem [DEPTH];
    logic [4:0]       rdata_q;

    logic             code_ok;
    logic             wr_en;
    logic             fetch_en;
    logic             xfer;

    // Write qualification; a clear discards any write in the same cycle
    always_comb begin
        code_ok = (error_in == 3'd0) && (code_in <= 5'd25);
        wr_en   = new_code_in && code_ok && (count_q < DEPTH_C) && !clear_in;
        xfer    = letter_valid_out && letter_ready_in;
    end

    // Storage array with registered read port (BRAM style, no reset)
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= code_in;
        end
        if (fetch_en) begin
            rdata_q <= mem[rd_ptr_q];
        end
    end

    // Output FSM: state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM: next state; the held letter leaves only on a transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (stored_q != '0) state_d = S_FETCH;
            S_FETCH: state_d = S_HOLD;
            S_HOLD:  if (letter_ready_in) state_d = (stored_q != '0) ? S_FETCH : S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
        if (clear_in) begin
            state_d = S_EMPTY;
        end
    end

    // Output FSM: outputs; letter is masked to zero whenever nothing is held
    always_comb begin
        fetch_en         = (state_q == S_FETCH);
        letter_valid_out = (state_q == S_HOLD);
        letter_out       = (state_q == S_HOLD) ? rdata_q : 5'd0;
    end

    // Pointers, occupancy, sticky flag and saturating counters
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        stored_d   = stored_q;
        overflow_d = overflow_q;
        bad_d      = bad_q;
        evt_d      = evt_q;
        err_prev_d = (error_in != 3'd0);

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (fetch_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, xfer})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case ({wr_en, fetch_en})
            2'b10:   stored_d = stored_q + CNT_W'(1);
            2'b01:   stored_d = stored_q - CNT_W'(1);
            default: stored_d = stored_q;
        endcase

        // Full check uses the registered count, so a same-cycle transfer does not help
        if (new_code_in && code_ok && (count_q == DEPTH_C)) begin
            overflow_d = 1'b1;
        end
        if (new_code_in && !code_ok && (bad_q != 8'hFF)) begin
            bad_d = bad_q + 8'd1;
        end
        if ((error_in != 3'd0) && !err_prev_q && (evt_q != 8'hFF)) begin
            evt_d = evt_q + 8'd1;
        end

        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            stored_d   = '0;
            overflow_d = 1'b0;
            bad_d      = 8'd0;
            evt_d      = 8'd0;
            err_prev_d = 1'b0;
        end
    end

    // Control and status registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stored_q   <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 8'd0;
            evt_q      <= 8'd0;
            err_prev_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stored_q   <= stored_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
            evt_q      <= evt_d;
            err_prev_q <= err_prev_d;
        end
    end

    // Status outputs
    always_comb begin
        count_out           = count_q;
        overflow_out        = overflow_q;
        bad_count_out       = bad_q;
        err_event_count_out = evt_q;
    end

endmodule

// File: tb/tb_ir_rx_letter_buffer.sv
// Testbench for ir_rx_letter_buffer (DEPTH = 4): directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_ir_rx_letter_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             clear_in;
    logic [4:0]       code_in;
    logic             new_code_in;
    logic [2:0]       error_in;
    logic             letter_ready_in;
    logic             letter_valid_out;
    logic [4:0]       letter_out;
    logic [CNT_W-1:0] count_out;
    logic             overflow_out;
    logic [7:0]       bad_count_out;
    logic [7:0]       err_event_count_out;

    ir_rx_letter_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .clear_in            (clear_in),
        .code_in             (code_in),
        .new_code_in         (new_code_in),
        .error_in            (error_in),
        .letter_ready_in     (letter_ready_in),
        .letter_valid_out    (letter_valid_out),
        .letter_out          (letter_out),
        .count_out           (count_out),
        .overflow_out        (overflow_out),
        .bad_count_out       (bad_count_out),
        .err_event_count_out (err_event_count_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [4:0] q[$];          // letters accepted and not yet handed over, in order
    int         m_bad;
    int         m_evt;
    logic       m_ovf;
    logic [2:0] m_err_prev;
    int         cyc = 0;
    int         last_xfer = -1;
    int         n_xfer = 0;
    bit         chk_spacing = 1'b0;
    bit         prev_valid = 1'b0;
    logic [4:0] prev_letter = 5'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bad      = 0;
        m_evt      = 0;
        m_ovf      = 1'b0;
        m_err_prev = 3'd0;
        prev_valid = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, update the model
    // from the rules, let the rising edge happen, then compare at the next fall.
    task automatic cycle(input bit nw, input logic [4:0] cd, input logic [2:0] er,
                         input bit rdy, input bit clr);
        bit xfer;
        bit ok;
        bit acc;
        new_code_in     = nw;
        code_in         = cd;
        error_in        = er;
        letter_ready_in = rdy;
        clear_in        = clr;
        #1;
        if (prev_valid) begin
            chk("hs_valid_held", 32'(letter_valid_out), 32'd1);
            chk("hs_letter_held", 32'(letter_out), 32'(prev_letter));
        end
        xfer = letter_valid_out && rdy;
        if (clr) begin
            model_reset();
        end else begin
            ok  = nw && (er == 3'd0) && (cd <= 5'd25);
            acc = ok && (q.size() < DEPTH);
            if (xfer) begin
                chk("xfer_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("xfer_letter", 32'(letter_out), 32'(q[0]));
                    if (chk_spacing && last_xfer >= 0) chk("xfer_spacing", 32'(cyc - last_xfer), 32'd2);
                    last_xfer = cyc;
                    n_xfer++;
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(cd);
            if (nw && !ok && m_bad < 255) m_bad++;
            if (ok && !acc) m_ovf = 1'b1;
            if (er != 3'd0 && m_err_prev == 3'd0 && m_evt < 255) m_evt++;
            m_err_prev = er;
        end
        prev_valid  = letter_valid_out && !xfer && !clr;
        prev_letter = letter_out;
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        chk("count", 32'(count_out), 32'(q.size()));
        chk("overflow", 32'(overflow_out), 32'(m_ovf));
        chk("bad_count", 32'(bad_count_out), 32'(m_bad));
        chk("err_events", 32'(err_event_count_out), 32'(m_evt));
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 3'd0, rdy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(letter_valid_out), 32'd0);
        chk({tag, "_letter"}, 32'(letter_out), 32'd0);
        chk({tag, "_count"}, 32'(count_out), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_out), 32'd0);
        chk({tag, "_bad"}, 32'(bad_count_out), 32'd0);
        chk({tag, "_evt"}, 32'(err_event_count_out), 32'd0);
    endtask

    initial begin
        int n0;
        bit rnw;
        logic [4:0] rcd;
        logic [2:0] rer;
        bit rrdy;
        bit rclr;

        rst_in = 1'b1; clear_in = 1'b0; code_in = 5'd0; new_code_in = 1'b0;
        error_in = 3'd0; letter_ready_in = 1'b0;
        model_reset();

        // Power-on reset, checked before any clock edge
        #2 rst_in = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b1;

        // Single letter: valid exactly two edges after the write edge
        cycle(1'b1, 5'd7, 3'd0, 1'b1, 1'b0);
        chk("t1_valid_e0", 32'(letter_valid_out), 32'd0);
        cycle(1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        chk("t1_valid_e1", 32'(letter_valid_out), 32'd0);
        cycle(1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        chk("t1_valid_e2", 32'(letter_valid_out), 32'd1);
        chk("t1_letter", 32'(letter_out), 32'd7);
        chk("t1_count_before", 32'(count_out), 32'd1);
        cycle(1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        chk("t1_count_after", 32'(count_out), 32'd0);
        chk("t1_valid_after", 32'(letter_valid_out), 32'd0);

        // Burst with backpressure, then drain at one letter per two cycles
        cycle(1'b1, 5'd0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd1, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd2, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd25, 3'd0, 1'b0, 1'b0);
        idle(1'b0, 3);
        chk("t2_held_letter", 32'(letter_out), 32'd0);
        n0 = n_xfer;
        chk_spacing = 1'b1;
        last_xfer = -1;
        idle(1'b1, 10);
        chk_spacing = 1'b0;
        chk("t2_xfers", 32'(n_xfer - n0), 32'd4);
        chk("t2_count", 32'(count_out), 32'd0);

        // Rejection of out-of-range and errored codes
        cycle(1'b1, 5'd26, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd31, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd5, 3'b010, 1'b0, 1'b0);
        idle(1'b0, 3);
        chk("t3_bad", 32'(bad_count_out), 32'd3);
        chk("t3_evt", 32'(err_event_count_out), 32'd1);
        chk("t3_count", 32'(count_out), 32'd0);
        chk("t3_valid", 32'(letter_valid_out), 32'd0);

        // Overflow, then drain and refill across pointer wrap
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'(10 + i), 3'd0, 1'b0, 1'b0);
        chk("t4_count_full", 32'(count_out), 32'd4);
        chk("t4_overflow", 32'(overflow_out), 32'd1);
        idle(1'b0, 2);
        n0 = n_xfer;
        idle(1'b1, 12);
        chk("t4_drain_xfers", 32'(n_xfer - n0), 32'd4);
        chk("t4_drained", 32'(count_out), 32'd0);
        n0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 5'(20 + i), 3'd0, 1'b1, 1'b0);
            cycle(1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        end
        idle(1'b1, 8);
        chk("t4_wrap_xfers", 32'(n_xfer - n0), 32'd5);
        chk("t4_wrap_count", 32'(count_out), 32'd0);

        // Write in the same cycle as a transfer
        cycle(1'b1, 5'd3, 3'd0, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("t5_hold", 32'(letter_valid_out), 32'd1);
        n0 = n_xfer;
        cycle(1'b1, 5'd4, 3'd0, 1'b1, 1'b0);
        chk("t5_count_same", 32'(count_out), 32'd1);
        idle(1'b1, 6);
        chk("t5_xfers", 32'(n_xfer - n0), 32'd2);

        // Asynchronous reset while holding a letter
        cycle(1'b1, 5'd9, 3'd0, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("t6_hold", 32'(letter_valid_out), 32'd1);
        rst_in = 1'b0;
        #1 chk_all_zero("t6_rst");
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(1'b0, 3);
        chk("t6_after_valid", 32'(letter_valid_out), 32'd0);

        // Synchronous clear while holding, with a write in the clear cycle
        cycle(1'b1, 5'd30, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd11, 3'd0, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("t7_hold", 32'(letter_valid_out), 32'd1);
        cycle(1'b1, 5'd12, 3'd0, 1'b0, 1'b1);
        chk_all_zero("t7_clr");
        idle(1'b1, 3);
        chk("t7_after_valid", 32'(letter_valid_out), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnw  = ($urandom_range(0, 1) == 1);
            rcd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
            rer  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rrdy = ($urandom_range(0, 2) != 0);
            rclr = ($urandom_range(0, 99) == 0);
            cycle(rnw, rcd, rer, rrdy, rclr);
        end
        idle(1'b1, 12);
        chk("rand_drained", 32'(count_out), 32'd0);
        chk("rand_valid", 32'(letter_valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_rx_letter_buffer.md
# ir_rx_letter_buffer

Receive-side letter buffer for the IR link. It captures 5-bit letter codes from the IR decoder (`ir_decoder`) as they arrive and discards corrupted or out-of-range codes. Accepted letters are held in a circular buffer and delivered one at a time over a valid/ready handshake to the Enigma decoder and the text display. It is the receive-side counterpart of the transmit-side BRAM that feeds `ir_transmitter`.

## Interface

Parameters:
- `DEPTH`, 1000, number of letters the buffer can hold.
- `CNT_W`, `$clog2(DEPTH+1)`, width of the occupancy count.

Ports:
- `clk_in`  input  1  system clock (100 MHz domain).
- `rst_in`  input  1  reset, asynchronous, active-low.
- `clear_in`  input  1  synchronous clear; empties the buffer and clears all counters and flags.
- `code_in`  input  5  letter code from the IR decoder; valid only when `new_code_in` is high.
- `new_code_in`  input  1  single-cycle strobe: `code_in` is a newly received letter.
- `error_in`  input  3  IR decoder error code; any nonzero value means an error.
- `letter_ready_in`  input  1  downstream consumer can accept a letter.
- `letter_valid_out`  output  1  `letter_out` holds a letter.
- `letter_out`  output  5  letter value, 0–25 (A–Z).
- `count_out`  output  CNT_W  letters accepted but not yet transferred, including the output register.
- `overflow_out`  output  1  sticky; set when a valid letter was dropped because the buffer was full.
- `bad_count_out`  output  8  saturating count of dropped codes: errored or out-of-range (> 25).
- `err_event_count_out`  output  8  saturating count of `error_in` transitions from zero to nonzero.

## Operation

- **Write qualification.** On a cycle with `new_code_in` high, the code is written only if all of the following hold:
  - `error_in == 0`;
  - `code_in <= 25`;
  - `count_out < DEPTH`.
- **Rejected writes.**
  - Codes failing either of the first two conditions are dropped, and `bad_count_out` increments (saturating at 255).
  - A code that passes both but finds the buffer full is dropped, and `overflow_out` is set. `bad_count_out` is not changed.
- **Storage.**
  - Array of DEPTH × 5 bits with a registered (1-cycle) read port, inferable as BRAM.
  - Write pointer and read pointer each wrap from DEPTH-1 to 0. DEPTH need not be a power of 2.
- **Output FSM.**
  - EMPTY: `letter_valid_out` = 0. Goes to FETCH when the storage is non-empty.
  - FETCH: read issued at the read pointer, which then advances. Goes to HOLD next cycle.
  - HOLD: `letter_valid_out` = 1 and `letter_out` = the fetched data, both stable until a transfer.
    - Transfer occurs when `letter_valid_out` and `letter_ready_in` are both high.
    - On transfer: goes to FETCH if the storage (excluding the output register) is non-empty, otherwise to EMPTY.
- **Count.** `count_out` increments on an accepted write and decrements on a transfer. If both happen in the same cycle it is unchanged.
- **Error events.** `err_event_count_out` increments when `error_in` goes from zero to nonzero; `error_in` is registered for edge detection. Saturates at 255.
- **Clear.** `clear_in` has priority over everything except reset. It returns the block to its reset state on the next edge, and a write presented in the same cycle is discarded.

## Timing

- **Reset values.** Asserting `rst_in` immediately forces:
  - `letter_valid_out` = 0, `letter_out` = 0;
  - `count_out` = 0, `overflow_out` = 0;
  - both counters = 0;
  - both pointers = 0, state = EMPTY.
- **Latency.** With the block in EMPTY, a write on edge N gives FETCH on cycle N+1 and `letter_valid_out` = 1 on cycle N+2.
- **Throughput.** After a transfer on cycle k with more letters stored, `letter_valid_out` drops for cycle k+1 and is high again on cycle k+2. This gives at most one letter every 2 cycles, which is far above the IR letter rate.
- **Handshake.** `letter_out` must not change while `letter_valid_out` is high and no transfer has occurred. `letter_valid_out` must never drop without a transfer, except on reset or clear.
- **Simultaneous events.**
  - A write and a transfer in the same cycle are both performed.
  - A write into an empty buffer while in HOLD does not disturb the held letter.
- **Full buffer.** A write is refused when `count_out == DEPTH`, even if a transfer happens in that same cycle. The freed slot becomes usable from the next cycle.
- **Reset during operation.** Reset mid-handshake or mid-FETCH discards the letter in flight; no partial state remains.

## Test plan

- **Single letter.** Reset, then write code 7 with `letter_ready_in` = 1. Required: `letter_valid_out` goes high exactly 2 cycles after the write, `letter_out` = 7, and `count_out` goes 1 → 0 after the transfer.
- **Burst with backpressure.** Write 0, 1, 2, 25 on consecutive strobes with `letter_ready_in` = 0, then raise ready. Required: output order 0, 1, 2, 25, one letter every 2 cycles, and `letter_out` held stable while ready is low.
- **Rejection.** Present codes 26 and 31, and code 5 with `error_in` = 3'b010. Required: nothing is buffered, `bad_count_out` = 3, and `err_event_count_out` = 1.
- **Overflow and wrap.** With DEPTH = 4 and ready low, write 6 letters. Required: `count_out` = 4 and `overflow_out` = 1. Then drain and write 5 more, checking that order is correct across pointer wrap.
- **Simultaneous write and transfer.** Write during the transfer cycle of an earlier letter. Required: `count_out` is unchanged in that cycle and both letters are delivered.
- **Reset and clear during a transfer.** Assert `rst_in` low while in HOLD. Required: all outputs are 0 immediately. Repeat with `clear_in`: all outputs are 0 on the next edge.
